// File: rtl/grid_param_pkg.sv
// rtl/grid_param_pkg.sv - shared types and sizes for the grid parameter loader
package grid_param_pkg;

  localparam int DATA_W          = 368;
  localparam int ROWS            = 256;
  localparam int ADDR_W          = $clog2(ROWS);
  localparam int IDX_W           = 3;
  localparam int SLICES          = DATA_W / 16;
  localparam int DEF_NUM_CORES   = 6;
  localparam int DEF_OUTPUT_CORE = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADVANCE,
    ST_DONE
  } load_state_e;

  function automatic logic [15:0] row_xor16(input logic [DATA_W-1:0] row);
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < SLICES; i++) begin
      x ^= row[i*16 +: 16];
    end
    return x;
  endfunction

endpackage

// File: rtl/grid_param_load_ctrl_if.sv
// rtl/grid_param_load_ctrl_if.sv - row stream, command and per-core parameter bus
interface grid_param_load_ctrl_if
  import grid_param_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES
) ();

  logic                 start;
  logic                 abort;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;
  logic [NUM_CORES-1:0] param_wen;
  logic [ADDR_W-1:0]    param_address;
  logic [DATA_W-1:0]    param_data;
  logic [IDX_W-1:0]     core_idx;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [15:0]          checksum;

  modport master (
    output start, abort, s_valid, s_data,
    input  s_ready, param_wen, param_address, param_data,
    input  core_idx, busy, done, error, checksum
  );

  modport slave (
    input  start, abort, s_valid, s_data,
    output s_ready, param_wen, param_address, param_data,
    output core_idx, busy, done, error, checksum
  );

endinterface

// File: rtl/param_core_sel.sv
// rtl/param_core_sel.sv - next-core step (skipping the output bus slot) and one-hot decode
module param_core_sel
  import grid_param_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int OUTPUT_CORE = DEF_OUTPUT_CORE
) (
  input  logic [IDX_W-1:0]     core_idx_i,
  output logic [IDX_W-1:0]     next_idx_o,
  output logic                 next_last_o,
  output logic [NUM_CORES-1:0] onehot_o
);

  logic [IDX_W:0] step;
  logic [IDX_W:0] sum;

  always_comb begin
    step = {1'b0, core_idx_i} + (IDX_W+1)'(1);
    sum  = step;
    if (step == (IDX_W+1)'(OUTPUT_CORE)) begin
      sum = step + (IDX_W+1)'(1);
    end
    next_idx_o  = sum[IDX_W-1:0];
    next_last_o = (sum >= (IDX_W+1)'(NUM_CORES));
    // The output-bus slot is excluded so its enable can never fire.
    onehot_o = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((core_idx_i == IDX_W'(i)) && (i != OUTPUT_CORE)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_param_load_ctrl.sv
// rtl/grid_param_load_ctrl.sv - streams parameter rows into grid cores; PARAM_LOAD_CHECKSUM_EN adds a row checksum
module grid_param_load_ctrl
  import grid_param_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int OUTPUT_CORE = DEF_OUTPUT_CORE
) (
  input  logic                   clk,
  input  logic                   reset,
  grid_param_load_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] FIRST_CORE = (OUTPUT_CORE == 0) ? IDX_W'(1) : IDX_W'(0);
  localparam logic [ADDR_W:0]  LAST_ROW   = (ADDR_W+1)'(ROWS - 1);

  load_state_e          state_q;
  logic                 s_ready_q;
  logic [NUM_CORES-1:0] param_wen_q;
  logic [ADDR_W-1:0]    param_address_q;
  logic [DATA_W-1:0]    param_data_q;
  logic [IDX_W-1:0]     core_idx_q;
  logic [ADDR_W:0]      row_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic [IDX_W-1:0]     next_idx;
  logic                 next_last;
  logic [NUM_CORES-1:0] core_onehot;
  logic                 accept;
  logic                 start_take;

  param_core_sel #(
    .NUM_CORES   (NUM_CORES),
    .OUTPUT_CORE (OUTPUT_CORE)
  ) u_core_sel (
    .core_idx_i  (core_idx_q),
    .next_idx_o  (next_idx),
    .next_last_o (next_last),
    .onehot_o    (core_onehot)
  );

  // s_ready_q is high exactly while in LOAD, so accept implies LOAD.
  assign accept     = bus.s_valid && s_ready_q && !bus.abort;
  assign start_take = (state_q == ST_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      s_ready_q       <= 1'b0;
      param_wen_q     <= '0;
      param_address_q <= '0;
      param_data_q    <= '0;
      core_idx_q      <= '0;
      row_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      param_wen_q <= '0;
      if (bus.s_valid && (state_q != ST_LOAD)) begin
        error_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_take) begin
            state_q    <= ST_LOAD;
            core_idx_q <= FIRST_CORE;
            row_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            s_ready_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b1;
          end else if (accept) begin
            param_wen_q     <= core_onehot;
            param_address_q <= row_q[ADDR_W-1:0];
            param_data_q    <= bus.s_data;
            row_q           <= row_q + (ADDR_W+1)'(1);
            if (row_q == LAST_ROW) begin
              state_q   <= ST_ADVANCE;
              s_ready_q <= 1'b0;
            end
          end
        end
        ST_ADVANCE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            core_idx_q <= next_idx;
            row_q      <= '0;
            if (next_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              s_ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PARAM_LOAD_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_take) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + row_xor16(bus.s_data);
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.s_ready       = s_ready_q;
  assign bus.param_wen     = param_wen_q;
  assign bus.param_address = param_address_q;
  assign bus.param_data    = param_data_q;
  assign bus.core_idx      = core_idx_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_grid_param_load_ctrl.sv
// tb/tb_grid_param_load_ctrl.sv - directed vector and load-sequence bench for grid_param_load_ctrl
module tb_grid_param_load_ctrl;
  import grid_param_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grid_param_load_ctrl_if bus ();

  grid_param_load_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       ab;
    logic       sv;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
    logic [5:0] exp_wen;
  } vec_t;

  vec_t        vecs[16];
  int          errors = 0;
  int          checks = 0;
  int          wcount = 0;
  int          acc = 0;
  bit          mon_en = 1'b0;
  bit          ones_mode = 1'b0;
  logic [15:0] cks_model = '0;
  int          cyc;

  function automatic logic [DATA_W-1:0] mkdata(input int n, input bit ones);
    logic [15:0] a;
    logic [15:0] b;
    if (ones) return '1;
    a = 16'(n);
    b = 16'(n * 37 + 11);
    return {{11{a, b}}, a ^ 16'hC3C3};
  endfunction

  function automatic logic [15:0] xor16(input logic [DATA_W-1:0] d);
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < DATA_W / 16; i++) x = x ^ d[i*16 +: 16];
    return x;
  endfunction

  function automatic logic [15:0] exp_cks();
`ifdef PARAM_LOAD_CHECKSUM_EN
    return cks_model;
`else
    return 16'h0;
`endif
  endfunction

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Each write is compared against the beat order since the last start.
  always @(posedge clk) begin
    #1;
    if (mon_en && bus.param_wen != '0) begin
      int         c;
      logic [5:0] ew;
      c = wcount / ROWS;
      if (c >= DEF_OUTPUT_CORE) c++;
      ew = 6'(1 << c);
      check("write_wen_addr", {bus.param_wen, bus.param_address}, {ew, 8'(wcount % ROWS)});
      check("write_data", bus.param_data, mkdata(wcount, ones_mode));
      wcount++;
    end
  end

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    acc = 0;
    wcount = 0;
    cks_model = '0;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, output int cycles);
    cycles = 0;
    while (acc < n && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (bus.s_ready && ($urandom_range(99) >= gap)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = mkdata(acc, ones_mode);
        cks_model   = cks_model + xor16(bus.s_data);
        acc++;
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    if (acc < n) check("feed_timeout", DATA_W'(acc), DATA_W'(n));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_load(input string nm);
    @(negedge clk);
    bus.s_valid = 1'b0;
    wait_done();
    check({nm, "_done"}, {bus.done, bus.busy, bus.error}, 3'b100);
    check({nm, "_writes"}, DATA_W'(wcount), DATA_W'(1280));
    check({nm, "_checksum"}, bus.checksum, exp_cks());
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 6'h00};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 0, 1, 6'h00};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 6'h00};
    vecs[3]  = '{0, 1, 0, 0, 1, 1, 0, 0, 6'h00};
    vecs[4]  = '{0, 1, 0, 0, 1, 1, 0, 0, 6'h00};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 0, 1, 6'h00};
    vecs[6]  = '{0, 0, 1, 0, 0, 0, 0, 1, 6'h00};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 1, 6'h00};
    vecs[8]  = '{0, 1, 0, 0, 1, 1, 0, 0, 6'h00};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 6'h00};
    vecs[10] = '{0, 1, 0, 0, 1, 1, 0, 0, 6'h00};
    vecs[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 6'h01};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 6'h00};
    vecs[13] = '{0, 0, 1, 1, 0, 0, 0, 1, 6'h00};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 6'h00};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 6'h00};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      bus.start   = vecs[i].st;
      bus.abort   = vecs[i].ab;
      bus.s_valid = vecs[i].sv;
      bus.s_data  = mkdata(0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {bus.s_ready, bus.busy, bus.done, bus.error, bus.param_wen},
            {vecs[i].exp_ready, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_wen});
    end
    check("reset_addr_data_cks", {bus.param_address, bus.param_data, bus.core_idx, bus.checksum}, '0);

    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    mon_en = 1'b1;

    // Back-to-back load: 1280 beats plus one bubble per core change.
    do_start();
    feed(1280, 0, cyc);
    check("full_cycles", DATA_W'(cyc), DATA_W'(1284));
    finish_load("full");
    repeat (3) @(negedge clk);
    check("done_sticky", {bus.done, bus.busy}, 2'b10);

    do_start();
    feed(1280, 30, cyc);
    finish_load("gaps");

    ones_mode = 1'b1;
    do_start();
    feed(1280, 0, cyc);
    finish_load("ones");
`ifdef PARAM_LOAD_CHECKSUM_EN
    check("ones_checksum_const", bus.checksum, 16'hFB00);
`endif
    ones_mode = 1'b0;

    // Abort at core 2 row 100 with a beat offered in the same cycle.
    do_start();
    feed(612, 0, cyc);
    @(negedge clk);
    bus.abort   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = mkdata(612, 1'b0);
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    check("abort_state", {bus.error, bus.busy, bus.param_wen, bus.s_ready}, {1'b1, 1'b0, 6'h00, 1'b0});
    repeat (2) @(negedge clk);
    check("abort_writes", DATA_W'(wcount), DATA_W'(612));

    do_start();
    feed(3, 0, cyc);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("restart_writes", DATA_W'(wcount), DATA_W'(3));
    check("restart_state", {bus.error, bus.busy}, 2'b01);

    // Reset in the middle of core 3.
    feed(818, 0, cyc);
    @(negedge clk);
    reset       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = mkdata(818, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_ctrl",
          {bus.s_ready, bus.param_wen, bus.param_address, bus.core_idx, bus.busy, bus.done, bus.error, bus.checksum},
          '0);
    check("midreset_data", bus.param_data, '0);
    @(negedge clk);
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_writes", DATA_W'(wcount), DATA_W'(818));
    check("midreset_idle", {bus.s_ready, bus.busy, bus.error}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_param_load_ctrl.md
Name: grid_param_load_ctrl

Overview:
Sequencer that streams per-core parameter rows into the compute cores of the 3x2 neuromorphic grid. It replaces the ad-hoc next_core steering mux. It accepts one 368-bit row per valid/ready beat and walks core 0..NUM_CORES-1, skipping the output-bus position. For each core it drives a one-hot write enable, an 8-bit row address and the row data, and raises done when every core holds ROWS rows. It sits between the clock-domain-crossing FIFO read side and the per-core param_wen/param_address/param_data_in inputs.

Parameters:
NUM_CORES, 6, grid positions (GRID_DIMENSION_X*GRID_DIMENSION_Y)
OUTPUT_CORE, 5, position occupied by the output bus; never written
ROWS, 256, rows per core parameter memory
DATA_W, 368, parameter row width
ADDR_W, 8, $clog2(ROWS)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: begin a load from core 0
abort  in  1  pulse: terminate load, return to IDLE
s_valid  in  1  upstream row valid
s_ready  out  1  controller accepts row this cycle
s_data  in  DATA_W  upstream row
param_wen  out  NUM_CORES  one-hot per-core write enable
param_address  out  ADDR_W  row address, shared by all cores
param_data  out  DATA_W  row data, shared by all cores
core_idx  out  3  core currently being loaded
busy  out  1  load in progress
done  out  1  sticky; all cores loaded
error  out  1  sticky; s_valid seen while not LOAD, or abort mid-load
checksum  out  16  load checksum (only when feature enabled, else tied 0)

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All outputs are registered.
- Reset values: s_ready=0, param_wen=0, param_address=0, param_data=0, core_idx=0, busy=0, done=0, error=0, checksum=0. State=IDLE.
- FSM states: IDLE, LOAD, ADVANCE, DONE.
  - IDLE: on start, go to LOAD. core_idx=0 (or 1 if OUTPUT_CORE==0), row counter=0, done cleared, error cleared, busy=1.
  - LOAD: s_ready=1. A beat is accepted when s_valid&&s_ready. On the following cycle the controller drives param_wen[core_idx]=1 for exactly one cycle, with param_address=row and param_data=s_data. Accept-to-write latency is 1 cycle.
  - Row counter increments per beat. After the beat with row==ROWS-1, go to ADVANCE; s_ready drops in the same cycle the last beat is accepted.
  - ADVANCE (1 cycle, s_ready=0): core_idx += 1, plus 1 more if the result equals OUTPUT_CORE. Row counter resets to 0. If the new index is >= NUM_CORES, go to DONE; else return to LOAD.
  - DONE: busy=0, done=1. Return to IDLE the next cycle; done stays high until the next start or reset.
- Row counter is ADDR_W+1 bits so it cannot wrap silently. Address emitted = counter[ADDR_W-1:0].
- Back-pressure: s_valid low in LOAD inserts bubbles with no write. Rows are never dropped or duplicated.
- start while busy is ignored. abort has priority over start and over beat acceptance in the same cycle. abort during LOAD/ADVANCE sets error=1 and returns to IDLE with param_wen=0 the next cycle. Partially written rows remain in the cores.
- s_valid high in IDLE/ADVANCE/DONE is not consumed (s_ready=0) and sets error=1.
- reset mid-load: all state and outputs return to reset values the next edge; no further param_wen.
- At most one param_wen bit is high in any cycle. param_wen[OUTPUT_CORE] is never high.

Optional Feature:
PARAM_LOAD_CHECKSUM_EN. Defined: checksum accumulates, mod 2^16, the XOR of the 23 16-bit slices of every accepted row. It clears on start and freezes in DONE. Undefined: checksum is constant 0 and no accumulator logic is synthesised.

Decomposition:
- Shared package grid_param_pkg: state enum (IDLE/LOAD/ADVANCE/DONE), DATA_W=368, ROWS=256, ADDR_W, and the default NUM_CORES/OUTPUT_CORE values.
- One sub-module: param_core_sel. Combinational next-core computation (increment, skip OUTPUT_CORE, last-core flag) plus the one-hot decode of core_idx.

Test Plan:
- Reset, start, 1280 back-to-back beats with row = {core,row} pattern -> param_wen walks 0x01,0x02,0x04,0x08,0x10, each high 256 cycles; address 0..255 per core; one bubble per ADVANCE; done=1 after the last write; bit 5 never set.
- Random s_valid gaps (about 30% idle) -> exactly 1280 writes, each address/data pair matching the beat order, no duplicates.
- abort at core 2, row 100 -> error=1, busy=0, param_wen=0 next cycle; a subsequent start reloads from core 0, row 0.
- s_valid=1 in IDLE before start -> s_ready=0, error=1, no param_wen.
- reset asserted mid-core 3 -> all outputs 0 at the next edge, state IDLE.
- With PARAM_LOAD_CHECKSUM_EN, all rows 0xFFFF-sliced (23 slices) -> per-row XOR 0xFFFF; checksum=(1280*0xFFFF) mod 2^16=0xFB00.
